// File: rtl/y86_seq_controller_if.sv
// Bundle of control/status signals between the Y86-64 datapath and its
// multi-cycle sequencer.
interface y86_seq_controller_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_error;
    logic             dmem_error;
    logic             mem_ready;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pcupd_en;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, icode, instr_valid, imem_error, dmem_error, mem_ready,
               alu_zf, alu_sf, alu_of,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en,
               cc_zf, cc_sf, cc_of, stat, busy, instr_count, cycle_count
    );

    modport slave (
        input  start, icode, instr_valid, imem_error, dmem_error, mem_ready,
               alu_zf, alu_sf, alu_of,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en,
               cc_zf, cc_sf, cc_of, stat, busy, instr_count, cycle_count
    );
endinterface

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 core: stage enables,
// condition codes, processor status and retire/cycle counters.
module y86_seq_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    y86_seq_controller_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WRITEBACK, S_PCUPD, S_HALT, S_ERROR
    } state_t;

    localparam int         WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t             state_q, state_d;
    logic [2:0]         stat_q, stat_d;
    logic [2:0]         cc_q, cc_d;          // {zf, sf, of}
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic [CNT_W-1:0]   ccnt_q, ccnt_d;
    logic [5:0]         en_q, en_d;          // {F, D, E, M, W, P}
    logic               busy;
    logic               is_mem;

    assign busy   = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
    assign is_mem = bus.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        cc_d    = cc_q;
        wait_d  = wait_q;
        icnt_d  = icnt_q;
        ccnt_d  = busy ? ccnt_q + CNT_W'(1) : ccnt_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_error) begin
                    state_d = S_ERROR;
                    stat_d  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    state_d = S_ERROR;
                    stat_d  = STAT_INS;
                end else if (bus.icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                    icnt_d  = icnt_q + CNT_W'(1);
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (bus.icode == 4'h6) cc_d = {bus.alu_zf, bus.alu_sf, bus.alu_of};
                if (is_mem) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (bus.dmem_error) begin
                    state_d = S_ERROR;
                    stat_d  = STAT_ADR;
                end else if (bus.mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // this cycle is the last permitted wait without mem_ready
                    state_d = S_ERROR;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                icnt_d  = icnt_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_comb begin
        en_d = '0;
        case (state_d)
            S_FETCH:     en_d = 6'b100000;
            S_DECODE:    en_d = 6'b010000;
            S_EXECUTE:   en_d = 6'b001000;
            S_MEMORY:    en_d = 6'b000100;
            S_WRITEBACK: en_d = 6'b000010;
            S_PCUPD:     en_d = 6'b000001;
            default:     en_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            cc_q    <= 3'b100;
            wait_q  <= '0;
            icnt_q  <= '0;
            ccnt_q  <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cc_q    <= cc_d;
            wait_q  <= wait_d;
            icnt_q  <= icnt_d;
            ccnt_q  <= ccnt_d;
            en_q    <= en_d;
        end
    end

    assign {bus.fetch_en, bus.decode_en, bus.execute_en,
            bus.memory_en, bus.writeback_en, bus.pcupd_en} = en_q;
    assign {bus.cc_zf, bus.cc_sf, bus.cc_of} = cc_q;
    assign bus.stat        = stat_q;
    assign bus.busy        = busy;
    assign bus.instr_count = icnt_q;
    assign bus.cycle_count = ccnt_q;
endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Multi-cycle sequencer for the sequential Y86-64 core.
- Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC-update.
- Emits a one-hot stage enable per cycle and owns the architectural condition-code register (ZF/SF/OF) that feeds the execute stage's cmovXX/jXX evaluation.
- Tracks processor status (AOK/HLT/ADR/INS) plus retired-instruction and cycle counters.

Parameters:
- CNT_W, 32, width of instr_count and cycle_count.
- MEM_TIMEOUT, 16, max cycles MEMORY waits for mem_ready before raising ADR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; sampled in IDLE only.
- icode  in  4  instruction code from fetch; valid from end of FETCH until PC-update.
- instr_valid  in  1  fetch decoded a legal icode/ifun; sampled in FETCH.
- imem_error  in  1  fetch address error; sampled in FETCH.
- dmem_error  in  1  data-memory address error; sampled in MEMORY.
- mem_ready  in  1  data memory completed the access; sampled in MEMORY.
- alu_zf, alu_sf, alu_of  in  1 each  ALU flags for the current OPq.
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en  out  1 each  one-hot stage enables, registered.
- cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in any state except IDLE, HALT and ERROR.
- instr_count  out  CNT_W  retired instructions.
- cycle_count  out  CNT_W  cycles spent outside IDLE, HALT and ERROR.

Behaviour:
- Reset (synchronous, active-high, highest priority, valid mid-instruction):
  - state=IDLE; all enables=0; cc_zf=1, cc_sf=0, cc_of=0; stat=1.
  - busy=0; both counters=0; memory wait counter=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT, ERROR.
- Exactly one enable is high in each active state; all enables are low in IDLE, HALT and ERROR.
- IDLE -> FETCH when start=1.
- FETCH transitions, in priority order:
  - imem_error=1 -> ERROR, stat=3.
  - else instr_valid=0 -> ERROR, stat=4.
  - else icode=0 (halt) -> HALT, stat=2; instr_count increments for the halt instruction.
  - else -> DECODE.
- DECODE -> EXECUTE.
- EXECUTE:
  - If icode=6 (OPq), cc_* <= alu_* at the end of this cycle; the new values are visible from the next cycle.
  - CC is not written for any other icode.
  - cmovXX/jXX therefore see the flags of the most recent OPq.
  - Next state is MEMORY if icode is in {4,5,8,9,A,B}; otherwise WRITEBACK.
- MEMORY: memory_en stays high while waiting. Priority order:
  - dmem_error=1 -> ERROR, stat=3.
  - else mem_ready=1 -> WRITEBACK.
  - else wait counter increments; reaching MEMORY_TIMEOUT wait cycles without mem_ready -> ERROR, stat=3.
  - Wait counter clears on entry to MEMORY.
- WRITEBACK -> PCUPD.
- PCUPD:
  - instr_count increments.
  - Next state is FETCH directly; no return to IDLE.
- HALT and ERROR are sticky until rst; start is ignored in them.
- Latency per instruction:
  - Non-memory: 5 cycles, FETCH through PCUPD.
  - Memory: 6 cycles plus mem_ready wait cycles.
- cycle_count increments on every clock with busy=1.
- Both counters wrap modulo 2^CNT_W without flagging.
- icode values 1 (nop), 2, 3, 7 and 0xC-0xF that pass instr_valid follow the non-memory path. Validity is fetch's responsibility.

Test Plan:
- rst, then start=1 for one cycle, OPq icode=6 with alu_zf=0, alu_sf=1, alu_of=0 -> enables walk F,D,E,W,P in 5 cycles; cc=(0,1,0) from the cycle after EXECUTE; instr_count=1; stat=1.
- mrmovq icode=5 with mem_ready asserted 3 cycles after MEMORY entry -> memory_en high for 4 cycles; instruction retires in 9 cycles; cc unchanged from reset (1,0,0).
- MEMORY with mem_ready held 0 and MEM_TIMEOUT=4 -> ERROR after 4 wait cycles; stat=3; busy=0; enables all 0; later start=1 has no effect.
- FETCH with instr_valid=0 -> ERROR, stat=4. Separately, icode=0 -> HALT, stat=2, instr_count increments by 1, cycle_count frozen thereafter.
- rst asserted while in MEMORY mid-wait -> next cycle state IDLE, cc=(1,0,0), counters=0, stat=1.
- OPq setting zf=1, then cmovXX icode=2, then jXX icode=7 -> cc stays (1,0,0) through both non-OPq instructions; no MEMORY state is entered.
